// File: rtl/trap_controller_pkg.sv
// Shared types and cause codes for the machine-mode trap controller.
package trap_controller_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_TRAP,
        ST_REDIRECT,
        ST_RETURN,
        ST_WAIT
    } trap_state_t;

    typedef enum logic [1:0] {
        TVAL_ZERO,
        TVAL_INSTR,
        TVAL_ADDR
    } tval_sel_t;

    typedef struct packed {
        logic illegal;
        logic ecall;
        logic ebreak;
        logic iaddr_mis;
        logic load_mis;
        logic store_mis;
    } exc_req_t;

    localparam logic [XLEN-1:0] EXC_IADDR_MIS = 32'd0;
    localparam logic [XLEN-1:0] EXC_ILLEGAL   = 32'd2;
    localparam logic [XLEN-1:0] EXC_BREAK     = 32'd3;
    localparam logic [XLEN-1:0] EXC_LOAD_MIS  = 32'd4;
    localparam logic [XLEN-1:0] EXC_STORE_MIS = 32'd6;
    localparam logic [XLEN-1:0] EXC_ECALL_M   = 32'd11;
    localparam logic [XLEN-1:0] IRQ_MTIMER    = 32'h8000_0007;
endpackage

// File: rtl/trap_controller_if.sv
// Datapath/CSR-unit bundle around the trap controller; slave is the controller side.
interface trap_controller_if;
    import trap_controller_pkg::*;

    logic            instr_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic            illegal_i;
    logic            ecall_i;
    logic            ebreak_i;
    logic            iaddr_mis_i;
    logic            load_mis_i;
    logic            store_mis_i;
    logic [XLEN-1:0] bad_addr_i;
    logic            mret_i;
    logic            wfi_i;
    logic            mtime_exc_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            jumpingToMtvec_o;
    logic [XLEN-1:0] excCause_o;
    logic [XLEN-1:0] trapInfo_o;
    logic [XLEN-1:0] trap_pc_o;
    logic            mret_o;
    logic            flush_o;
    logic            stall_o;
    logic            pc_load_o;
    logic [XLEN-1:0] pc_target_o;

    modport master (
        output instr_valid_i, pc_i, instr_i, illegal_i, ecall_i, ebreak_i,
               iaddr_mis_i, load_mis_i, store_mis_i, bad_addr_i, mret_i, wfi_i,
               mtime_exc_i, mtvec_i, mepc_i,
        input  jumpingToMtvec_o, excCause_o, trapInfo_o, trap_pc_o, mret_o,
               flush_o, stall_o, pc_load_o, pc_target_o
    );

    modport slave (
        input  instr_valid_i, pc_i, instr_i, illegal_i, ecall_i, ebreak_i,
               iaddr_mis_i, load_mis_i, store_mis_i, bad_addr_i, mret_i, wfi_i,
               mtime_exc_i, mtvec_i, mepc_i,
        output jumpingToMtvec_o, excCause_o, trapInfo_o, trap_pc_o, mret_o,
               flush_o, stall_o, pc_load_o, pc_target_o
    );
endinterface

// File: rtl/trap_controller_exc_priority_enc.sv
// Fixed-priority encoder: six exception requests -> {any, cause, tval source}.
module exc_priority_enc
    import trap_controller_pkg::*;
(
    input  exc_req_t        req,
    output logic            any,
    output logic [XLEN-1:0] cause,
    output tval_sel_t       tval_sel
);
    always_comb begin
        any      = 1'b1;
        cause    = '0;
        tval_sel = TVAL_ZERO;
        if (req.illegal) begin
            cause    = EXC_ILLEGAL;
            tval_sel = TVAL_INSTR;
        end else if (req.ecall) begin
            cause = EXC_ECALL_M;
        end else if (req.ebreak) begin
            cause = EXC_BREAK;
        end else if (req.iaddr_mis) begin
            cause    = EXC_IADDR_MIS;
            tval_sel = TVAL_ADDR;
        end else if (req.load_mis) begin
            cause    = EXC_LOAD_MIS;
            tval_sel = TVAL_ADDR;
        end else if (req.store_mis) begin
            cause    = EXC_STORE_MIS;
            tval_sel = TVAL_ADDR;
        end else begin
            any = 1'b0;
        end
    end
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer between datapath and CSR unit.
// Define TRAP_VECTORED_EN for vectored interrupt redirect; otherwise direct mode.
module trap_controller
    import trap_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    trap_controller_if.slave  bus
);
    trap_state_t     state_q, state_n;
    logic [XLEN-1:0] cause_q, tval_q, pc_q, wfi_pc_q;
    logic [XLEN-1:0] cause_n, tval_n, pc_n;
    logic            take_trap, take_wfi;

    exc_req_t        req;
    logic            enc_any;
    logic [XLEN-1:0] enc_cause, enc_tval, redirect_pc;
    tval_sel_t       enc_sel;

    logic            jump, mret_s, flush, stall, pc_load;
    logic [XLEN-1:0] pc_target;

    assign req = '{illegal:   bus.illegal_i,   ecall:    bus.ecall_i,
                   ebreak:    bus.ebreak_i,    iaddr_mis: bus.iaddr_mis_i,
                   load_mis:  bus.load_mis_i,  store_mis: bus.store_mis_i};

    exc_priority_enc u_enc (
        .req      (req),
        .any      (enc_any),
        .cause    (enc_cause),
        .tval_sel (enc_sel)
    );

    always_comb begin
        case (enc_sel)
            TVAL_INSTR: enc_tval = bus.instr_i;
            TVAL_ADDR:  enc_tval = bus.bad_addr_i;
            default:    enc_tval = '0;
        endcase
    end

    // Interrupt vectors are offset by 4*code; exceptions always use the base.
`ifdef TRAP_VECTORED_EN
    assign redirect_pc = cause_q[XLEN-1] ? bus.mtvec_i + {cause_q[XLEN-3:0], 2'b00}
                                         : bus.mtvec_i;
`else
    assign redirect_pc = bus.mtvec_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cause_q  <= '0;
            tval_q   <= '0;
            pc_q     <= '0;
            wfi_pc_q <= '0;
        end else begin
            state_q <= state_n;
            if (take_trap) begin
                cause_q <= cause_n;
                tval_q  <= tval_n;
                pc_q    <= pc_n;
            end
            if (take_wfi) wfi_pc_q <= bus.pc_i + 32'd4;
        end
    end

    always_comb begin
        state_n   = state_q;
        take_trap = 1'b0;
        take_wfi  = 1'b0;
        cause_n   = '0;
        tval_n    = '0;
        pc_n      = '0;
        jump      = 1'b0;
        mret_s    = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        case (state_q)
            ST_RUN: if (bus.instr_valid_i) begin
                if (enc_any) begin
                    flush = 1'b1; stall = 1'b1; take_trap = 1'b1;
                    cause_n = enc_cause; tval_n = enc_tval; pc_n = bus.pc_i;
                    state_n = ST_TRAP;
                end else if (bus.mtime_exc_i) begin
                    flush = 1'b1; stall = 1'b1; take_trap = 1'b1;
                    cause_n = IRQ_MTIMER; pc_n = bus.pc_i;
                    state_n = ST_TRAP;
                end else if (bus.mret_i) begin
                    flush   = 1'b1;
                    state_n = ST_RETURN;
                end else if (bus.wfi_i) begin
                    take_wfi = 1'b1;
                    state_n  = ST_WAIT;
                end
            end
            ST_TRAP: begin
                jump    = 1'b1;
                stall   = 1'b1;
                state_n = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_load   = 1'b1;
                pc_target = redirect_pc;
                stall     = 1'b1;
                state_n   = ST_RUN;
            end
            ST_RETURN: begin
                mret_s    = 1'b1;
                pc_load   = 1'b1;
                pc_target = bus.mepc_i;
                stall     = 1'b1;
                state_n   = ST_RUN;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.mtime_exc_i) begin
                    take_trap = 1'b1;
                    cause_n = IRQ_MTIMER; pc_n = wfi_pc_q;
                    state_n = ST_TRAP;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign bus.jumpingToMtvec_o = jump;
    assign bus.mret_o           = mret_s;
    assign bus.flush_o          = flush;
    assign bus.stall_o          = stall;
    assign bus.pc_load_o        = pc_load;
    assign bus.pc_target_o      = pc_target;
    assign bus.excCause_o       = cause_q;
    assign bus.trapInfo_o       = tval_q;
    assign bus.trap_pc_o        = pc_q;
endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus random traffic vs a frame-schedule model.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_controller_if tif ();
    trap_controller dut (.clk(clk), .rst(rst), .bus(tif));

    typedef struct {
        logic rst, valid, illegal, ecall, ebreak, iaddr, load, store, mret, wfi, mtime;
        logic [31:0] pc, instr, bad, mtvec, mepc;
    } stim_t;

    // One scheduled non-RUN cycle of output activity.
    typedef struct {
        bit jump, mret, load, mepc_sel;
    } frame_t;

    int          tests = 0;
    int          fails = 0;
    stim_t       nx;
    frame_t      sched[$];
    bit          m_wait = 0;
    logic [31:0] m_wait_pc = 0, m_cause = 0, m_tval = 0, m_pc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.mtvec = 32'h200;
        s.mepc  = 32'h104;
        return s;
    endfunction

    function automatic logic [31:0] vec_target(logic [31:0] base, logic [31:0] cause);
`ifdef TRAP_VECTORED_EN
        if (cause[31]) return base + 4 * (cause & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    task automatic cycle();
        frame_t      f;
        bit          trap_evt, mret_evt, wfi_evt, found;
        logic        b[6];
        int          codes[6];
        logic [31:0] n_cause, n_tval, n_pc, code;
        logic        e_jump, e_mret, e_flush, e_stall, e_load;
        logic [31:0] e_tgt;
        codes = '{2, 11, 3, 0, 4, 6};
        @(posedge clk);
        #1;
        rst = nx.rst;
        tif.instr_valid_i = nx.valid;  tif.pc_i = nx.pc;        tif.instr_i = nx.instr;
        tif.illegal_i = nx.illegal;    tif.ecall_i = nx.ecall;  tif.ebreak_i = nx.ebreak;
        tif.iaddr_mis_i = nx.iaddr;    tif.load_mis_i = nx.load; tif.store_mis_i = nx.store;
        tif.bad_addr_i = nx.bad;       tif.mret_i = nx.mret;    tif.wfi_i = nx.wfi;
        tif.mtime_exc_i = nx.mtime;    tif.mtvec_i = nx.mtvec;  tif.mepc_i = nx.mepc;
        #3;
        trap_evt = 0; mret_evt = 0; wfi_evt = 0; found = 0;
        n_cause = 0; n_tval = 0; n_pc = 0; code = 0;
        e_jump = 0; e_mret = 0; e_flush = 0; e_stall = 0; e_load = 0; e_tgt = 0;
        if (sched.size() > 0) begin
            f = sched[0];
            e_jump = f.jump; e_mret = f.mret; e_load = f.load; e_stall = 1;
            if (f.load) e_tgt = f.mepc_sel ? nx.mepc : vec_target(nx.mtvec, m_cause);
        end else if (m_wait) begin
            e_stall = 1;
            if (nx.mtime) begin
                trap_evt = 1; n_cause = IRQ_MTIMER; n_tval = 0; n_pc = m_wait_pc;
            end
        end else if (nx.valid) begin
            b = '{nx.illegal, nx.ecall, nx.ebreak, nx.iaddr, nx.load, nx.store};
            for (int i = 0; i < 6; i++)
                if (b[i] && !found) begin found = 1; code = codes[i]; end
            if (found || nx.mtime) begin
                e_flush = 1; e_stall = 1; trap_evt = 1; n_pc = nx.pc;
                n_cause = found ? code : IRQ_MTIMER;
                if (found && code == 2) n_tval = nx.instr;
                else if (found && (code == 0 || code == 4 || code == 6)) n_tval = nx.bad;
            end else if (nx.mret) begin
                e_flush = 1; mret_evt = 1;
            end else if (nx.wfi) begin
                wfi_evt = 1;
            end
        end
        chk("jump",    32'(tif.jumpingToMtvec_o), 32'(e_jump));
        chk("mret_o",  32'(tif.mret_o),    32'(e_mret));
        chk("flush",   32'(tif.flush_o),   32'(e_flush));
        chk("stall",   32'(tif.stall_o),   32'(e_stall));
        chk("pc_load", 32'(tif.pc_load_o), 32'(e_load));
        chk("target",  tif.pc_target_o,    e_tgt);
        chk("cause",   tif.excCause_o,     m_cause);
        chk("tval",    tif.trapInfo_o,     m_tval);
        chk("trap_pc", tif.trap_pc_o,      m_pc);
        // Advance the model across the clock edge.
        if (nx.rst) begin
            sched.delete();
            m_wait = 0; m_wait_pc = 0; m_cause = 0; m_tval = 0; m_pc = 0;
        end else begin
            if (sched.size() > 0) void'(sched.pop_front());
            if (trap_evt) begin
                m_wait = 0; m_cause = n_cause; m_tval = n_tval; m_pc = n_pc;
                sched.push_back('{1, 0, 0, 0});
                sched.push_back('{0, 0, 1, 0});
            end
            if (mret_evt) sched.push_back('{0, 1, 1, 1});
            if (wfi_evt) begin m_wait = 1; m_wait_pc = nx.pc + 32'd4; end
        end
    endtask

    task automatic chk_all_zero(string name);
        chk(name, {31'd0, tif.jumpingToMtvec_o | tif.mret_o | tif.flush_o | tif.stall_o | tif.pc_load_o}, 32'd0);
        chk(name, tif.pc_target_o | tif.excCause_o | tif.trapInfo_o | tif.trap_pc_o, 32'd0);
    endtask

    int jumps, stalls;

    initial begin
        nx = idle(); nx.rst = 1;
        cycle(); cycle();
        nx.rst = 0;
        cycle();
        chk_all_zero("reset_state");

        // Illegal instruction trap with full timing.
        nx = idle(); nx.valid = 1; nx.illegal = 1; nx.pc = 32'h100; nx.instr = 32'hFFFF_FFFF;
        cycle();
        chk("ill_flush", 32'(tif.flush_o), 1);
        nx = idle();
        cycle();
        chk("ill_strobe", 32'(tif.jumpingToMtvec_o), 1);
        chk("ill_cause", tif.excCause_o, 32'd2);
        chk("ill_tval", tif.trapInfo_o, 32'hFFFF_FFFF);
        chk("ill_pc", tif.trap_pc_o, 32'h100);
        cycle();
        chk("ill_load", 32'(tif.pc_load_o), 1);
        chk("ill_target", tif.pc_target_o, 32'h200);
        cycle();

        // Illegal + ecall + timer together: one strobe, cause 2.
        nx = idle(); nx.valid = 1; nx.illegal = 1; nx.ecall = 1; nx.mtime = 1; nx.pc = 32'h10;
        cycle();
        nx = idle(); jumps = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (tif.jumpingToMtvec_o) begin
                jumps++;
                chk("prio_cause", tif.excCause_o, 32'd2);
            end
        end
        chk("prio_one_strobe", jumps, 1);

        // Timer interrupt.
        nx = idle(); nx.valid = 1; nx.mtime = 1; nx.pc = 32'h40;
        cycle();
        chk("irq_flush", 32'(tif.flush_o), 1);
        nx = idle();
        cycle();
        chk("irq_cause", tif.excCause_o, 32'h8000_0007);
        chk("irq_pc", tif.trap_pc_o, 32'h40);
        cycle();
`ifdef TRAP_VECTORED_EN
        chk("irq_target", tif.pc_target_o, 32'h21C);
`else
        chk("irq_target", tif.pc_target_o, 32'h200);
`endif
        cycle();

        // WFI then timer 10 cycles later.
        nx = idle(); nx.valid = 1; nx.wfi = 1; nx.pc = 32'h80;
        cycle();
        chk("wfi_no_flush", 32'(tif.flush_o), 0);
        nx = idle(); stalls = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (tif.stall_o) stalls++;
        end
        chk("wfi_stall_hold", stalls, 10);
        nx.mtime = 1;
        cycle();
        nx = idle();
        cycle();
        chk("wfi_strobe", 32'(tif.jumpingToMtvec_o), 1);
        chk("wfi_pc", tif.trap_pc_o, 32'h84);
        cycle(); cycle();

        // MRET.
        nx = idle(); nx.valid = 1; nx.mret = 1; nx.mepc = 32'h104;
        cycle();
        nx = idle();
        cycle();
        chk("mret_strobe", 32'(tif.mret_o), 1);
        chk("mret_load", 32'(tif.pc_load_o), 1);
        chk("mret_target", tif.pc_target_o, 32'h104);
        cycle();

        // Reset while in TRAP.
        nx = idle(); nx.valid = 1; nx.ecall = 1; nx.pc = 32'h300;
        cycle();
        nx = idle(); nx.rst = 1;
        cycle();
        nx = idle();
        cycle();
        chk_all_zero("rst_mid_trap");
        jumps = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (tif.jumpingToMtvec_o) jumps++;
        end
        chk("rst_no_strobe", jumps, 0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            nx.rst     = ($urandom_range(99) == 0);
            nx.valid   = ($urandom_range(9) < 7);
            nx.illegal = ($urandom_range(11) == 0);
            nx.ecall   = ($urandom_range(11) == 0);
            nx.ebreak  = ($urandom_range(11) == 0);
            nx.iaddr   = ($urandom_range(11) == 0);
            nx.load    = ($urandom_range(11) == 0);
            nx.store   = ($urandom_range(11) == 0);
            nx.mret    = ($urandom_range(9) == 0);
            nx.wfi     = ($urandom_range(9) == 0);
            nx.mtime   = ($urandom_range(7) == 0);
            nx.pc      = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom;
            nx.instr   = $urandom;
            nx.bad     = $urandom;
            nx.mtvec   = $urandom & 32'hFFFF_FFFC;
            nx.mepc    = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
